// File: rtl/bcd_arb_pkg.sv
// ============================================================================
// Module      : bcd_arb_pkg
// Description : Shared types, default widths and helpers for bcd_conv_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_DW      = 8;
    localparam int DEF_BW      = 12;
    localparam int DEF_TIMEOUT = 64;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin one-hot grant starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_hi;
    logic [N_REQ-1:0] w_sel;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_mask[i] = (i >= int'(ptr));
        end
    end

    // Prefer requesters at/after the pointer; wrap to the lowest index otherwise.
    assign w_hi  = req & w_mask;
    assign w_sel = (|w_hi) ? w_hi : req;
    assign grant = w_sel & (~w_sel + N_REQ'(1));

endmodule

`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
// ============================================================================
// Module      : bcd_conv_arbiter
// Description : Round-robin scheduler sharing one serial binary-to-BCD
//               converter; optional WAIT timeout via BCD_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = DEF_DW,
    parameter int BW      = DEF_BW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [BW-1:0]       rsp_bcd,
    output logic                rsp_err,
    output logic                conv_enable,
    output logic [DW-1:0]       conv_data,
    input  logic [BW-1:0]       conv_bcd,
    input  logic                conv_done
);

    localparam int PW = ptr_w(N_REQ);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_START = ST_START;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_RESP  = ST_RESP;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("bcd_conv_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    logic [1:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_gnt_idx;
    logic [N_REQ-1:0] r_gnt_oh;
    logic [N_REQ-1:0] w_gnt_oh;
    logic [PW-1:0]    w_gnt_idx;
    logic [DW-1:0]    w_sel_data;
    logic             w_timeout;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_gnt_oh)
    );

    always_comb begin
        w_gnt_idx  = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_gnt_idx  = PW'(i);
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_wait_cnt;

    // Counter is zero on the first WAIT cycle, so expiry lands TIMEOUT cycles after entry.
    always_ff @(posedge clk) begin
        if (!rst_n || r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == CW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_oh    <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_bcd     <= '0;
            rsp_err     <= 1'b0;
            conv_enable <= 1'b0;
            conv_data   <= '0;
        end else begin
            req_ready   <= '0;
            rsp_valid   <= '0;
            conv_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_gnt_oh    <= w_gnt_oh;
                        r_gnt_idx   <= w_gnt_idx;
                        conv_data   <= w_sel_data;
                        req_ready   <= w_gnt_oh;
                        conv_enable <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (conv_done) begin
                        rsp_bcd   <= conv_bcd;
                        rsp_err   <= 1'b0;
                        rsp_valid <= r_gnt_oh;
                        r_state   <= S_RESP;
                    end else if (w_timeout) begin
                        rsp_bcd   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= r_gnt_oh;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ptr   <= (r_gnt_idx == PW'(N_REQ - 1)) ? '0 : r_gnt_idx + PW'(1);
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
// ============================================================================
// Module      : tb_bcd_conv_arbiter
// Description : Self-checking bench for bcd_conv_arbiter (vectors, corner
//               sequences and randomized traffic against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_conv_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int BW  = 12;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [BW-1:0]   rsp_bcd;
    logic            rsp_err;
    logic            conv_enable;
    logic [DW-1:0]   conv_data;
    logic [BW-1:0]   conv_bcd;
    logic            conv_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Converter model state
    bit            conv_auto;
    bit            m_pend;
    int            m_cnt;
    int            m_lat;
    logic [DW-1:0] m_opnd;

    typedef struct {
        int          idx;
        int          data;
        logic [11:0] exp_bcd;
        int          lat;
    } vec_t;

    vec_t        vecs[6];
    int          tdata[N];
    logic [11:0] texp[N];

    always #5 clk = ~clk;

    bcd_conv_arbiter #(
        .N_REQ   (N),
        .DW      (DW),
        .BW      (BW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_bcd     (rsp_bcd),
        .rsp_err     (rsp_err),
        .conv_enable (conv_enable),
        .conv_data   (conv_data),
        .conv_bcd    (conv_bcd),
        .conv_done   (conv_done)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int predict(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: wait for the falling edge, then step the converter model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (conv_auto) begin
            conv_done = 1'b0;
            conv_bcd  = 12'($urandom);
            if (!rst_n) begin
                m_pend = 1'b0;
            end else if (conv_enable) begin
                m_pend = 1'b1;
                m_opnd = conv_data;
                m_cnt  = m_lat;
            end else if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    conv_done = 1'b1;
                    conv_bcd  = to_bcd(int'(m_opnd));
                    m_pend    = 1'b0;
                end
            end
        end
    endtask

    task automatic set_req(input int i, input int d);
        req_valid[i]            = 1'b1;
        req_data[i*DW +: DW]    = DW'(d);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        conv_done = 1'b0;
        m_pend    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_single(input int idx, input int data, input logic [11:0] exp_bcd, input int lat);
        bit got;
        int rcyc;
        m_lat = lat;
        set_req(idx, data);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (|req_ready) got = 1;
        end
        if (!got) begin
            chk("single_ready_wait", 0, 1);
            req_valid = '0;
            return;
        end
        rcyc = cyc;
        chk("single_ready", 32'(req_ready), 32'(1 << idx));
        chk("single_enable", 32'(conv_enable), 1);
        chk("single_conv_data", 32'(conv_data), 32'(data));
        req_valid[idx] = 1'b0;
        tick();
        chk("single_enable_pulse", 32'({conv_enable, req_ready}), 0);
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            tick();
            if (|rsp_valid) got = 1;
        end
        if (!got) begin
            chk("single_rsp_wait", 0, 1);
            return;
        end
        chk("single_rsp_valid", 32'(rsp_valid), 32'(1 << idx));
        chk("single_rsp_bcd", 32'(rsp_bcd), 32'(exp_bcd));
        chk("single_rsp_err", 32'(rsp_err), 0);
        chk("single_latency", 32'(cyc - rcyc), 32'(lat + 1));
        tick();
        chk("single_rsp_pulse", 32'(rsp_valid), 0);
        chk("single_rsp_hold", 32'(rsp_bcd), 32'(exp_bcd));
    endtask

    // Serve a set of simultaneous requests and check grant/response order.
    task automatic serve_set(input logic [N-1:0] mask, input int order[N], input int n);
        int pos;
        int rpos;
        pos  = 0;
        rpos = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) set_req(i, tdata[i]);
        end
        for (int k = 0; k < 400 && rpos < n; k++) begin
            tick();
            if (|req_ready) begin
                if (pos < n) chk("order_grant", 32'(req_ready), 32'(1 << order[pos]));
                req_valid = req_valid & ~req_ready;
                pos++;
            end
            if (|rsp_valid) begin
                if (rpos < n) begin
                    chk("order_rsp_valid", 32'(rsp_valid), 32'(1 << order[rpos]));
                    chk("order_rsp_bcd", 32'(rsp_bcd), 32'(texp[order[rpos]]));
                end
                rpos++;
            end
        end
        chk("order_rsp_count", 32'(rpos), 32'(n));
        req_valid = '0;
    endtask

    initial begin
        int  ord[N];
        int  last_g;
        int  exp_g;
        int  rcyc;
        bit  got;
        bit  any;
        int  gq[$];
        logic [11:0] bq[$];
        int  dat[N];

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        conv_bcd  = '0;
        conv_done = 1'b0;
        conv_auto = 1'b1;
        m_pend    = 1'b0;
        m_cnt     = 0;
        m_lat     = 1;
        m_opnd    = '0;

        vecs[0] = '{0, 255, 12'h255, 3};
        vecs[1] = '{1,   0, 12'h000, 1};
        vecs[2] = '{2,   9, 12'h009, 2};
        vecs[3] = '{3,  99, 12'h099, 5};
        vecs[4] = '{1, 200, 12'h200, 4};
        vecs[5] = '{2, 128, 12'h128, 1};

        tick();
        tick();
        chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_bcd, rsp_err, conv_enable, conv_data}), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven single conversions
        for (int v = 0; v < 6; v++) begin
            do_single(vecs[v].idx, vecs[v].data, vecs[v].exp_bcd, vecs[v].lat);
        end

        // Contention from reset: grants 0,1,2,3
        do_reset();
        tdata = '{0, 9, 99, 200};
        texp  = '{12'h000, 12'h009, 12'h099, 12'h200};
        ord   = '{0, 1, 2, 3};
        m_lat = 2;
        serve_set(4'b1111, ord, 4);

        // Pointer wrap: after grant 2, requesters 1 and 3 -> 3 then 1
        do_reset();
        do_single(2, 55, 12'h055, 2);
        tdata = '{0, 42, 0, 7};
        texp  = '{12'h000, 12'h042, 12'h000, 12'h007};
        ord   = '{3, 1, 0, 0};
        serve_set(4'b1010, ord, 2);

        // Reset mid-WAIT with pointer moved away from 0
        do_reset();
        do_single(1, 137, 12'h137, 2);
        conv_auto = 1'b0;
        conv_done = 1'b0;
        set_req(2, 201);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (|req_ready) got = 1;
        end
        chk("rstwait_ready_seen", 32'(got), 1);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstwait_outputs", 32'({req_ready, rsp_valid, rsp_bcd, rsp_err, conv_enable, conv_data}), 0);
        conv_bcd  = 12'h201;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        any = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (|rsp_valid || |req_ready) any = 1;
        end
        chk("rstwait_late_done", 32'(any), 0);
        conv_auto = 1'b1;
        m_pend    = 1'b0;
        tdata = '{11, 0, 0, 33};
        texp  = '{12'h011, 12'h000, 12'h000, 12'h033};
        ord   = '{0, 3, 0, 0};
        serve_set(4'b1001, ord, 2);

        // Spurious done in IDLE
        conv_auto = 1'b0;
        conv_bcd  = 12'h777;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        any = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (|rsp_valid || |req_ready || conv_enable) any = 1;
        end
        chk("spurious_done", 32'(any), 0);
        conv_auto = 1'b1;
        m_pend    = 1'b0;
        do_single(3, 64, 12'h064, 3);

        // WAIT with no converter completion
        conv_auto = 1'b0;
        conv_done = 1'b0;
        set_req(1, 77);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (|req_ready) got = 1;
        end
        chk("tmo_ready_seen", 32'(got), 1);
        rcyc = cyc;
        req_valid = '0;
`ifdef BCD_ARB_TIMEOUT_EN
        got = 0;
        for (int k = 0; k < TMO + 20 && !got; k++) begin
            tick();
            if (|rsp_valid) got = 1;
        end
        chk("tmo_rsp_seen", 32'(got), 1);
        chk("tmo_delay", 32'(cyc - rcyc), 32'(TMO + 1));
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'(1 << 1));
        chk("tmo_rsp_err", 32'(rsp_err), 1);
        chk("tmo_rsp_bcd", 32'(rsp_bcd), 0);
        tick();
`else
        any = 0;
        for (int k = 0; k < TMO + 20; k++) begin
            tick();
            if (|rsp_valid || |req_ready) any = 1;
        end
        chk("wait_blocks", 32'(any), 0);
        conv_bcd  = 12'h077;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        chk("wait_release_valid", 32'(rsp_valid), 32'(1 << 1));
        chk("wait_release_bcd", 32'(rsp_bcd), 32'h077);
        chk("wait_release_err", 32'(rsp_err), 0);
        tick();
`endif
        conv_auto = 1'b1;

        // Randomized traffic against the round-robin reference model
        do_reset();
        last_g = N - 1;
        m_lat  = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (|req_ready) begin
                exp_g = predict(req_valid, last_g);
                chk("rand_grant", 32'(req_ready), (exp_g < 0) ? 0 : 32'(1 << exp_g));
                if (exp_g >= 0) begin
                    chk("rand_conv_data", 32'(conv_data), 32'(dat[exp_g]));
                    gq.push_back(exp_g);
                    bq.push_back(to_bcd(dat[exp_g]));
                    last_g = exp_g;
                end
                req_valid = req_valid & ~req_ready;
                m_lat = int'($urandom_range(6, 1));
            end
            if (|rsp_valid) begin
                if (gq.size() == 0) begin
                    chk("rand_unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    chk("rand_rsp_valid", 32'(rsp_valid), 32'(1 << gq[0]));
                    chk("rand_rsp_bcd", 32'(rsp_bcd), 32'(bq[0]));
                    chk("rand_rsp_err", 32'(rsp_err), 0);
                    void'(gq.pop_front());
                    void'(bq.pop_front());
                end
            end
            if (c < 2900) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && $urandom_range(3, 0) == 0) begin
                        dat[i] = int'($urandom_range(255, 0));
                        set_req(i, dat[i]);
                    end
                end
            end
        end
        chk("rand_drained", 32'(gq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
